// File: rtl/inta_sequencer_if.sv
// rtl/inta_sequencer_if.sv - PIC acknowledge pins and core vector handoff bundle
interface inta_sequencer_if;
  logic       int_req;
  logic       int_enable;
  logic [7:0] data_in;
  logic       inta_n;
  logic [7:0] vector;
  logic       vec_valid;
  logic       vec_ready;
  logic       busy;

  modport master (
    input  int_req, int_enable, data_in, vec_ready,
    output inta_n, vector, vec_valid, busy
  );

  modport slave (
    output int_req, int_enable, data_in, vec_ready,
    input  inta_n, vector, vec_valid, busy
  );
endinterface

// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - two-pulse INTA sequencer with vector capture and core handoff
module inta_sequencer #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input logic              clk,
  input logic              rst_n,
  inta_sequencer_if.master bus
);
  localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] P1   = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] P2   = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;
  localparam logic [2:0] COOL = 3'd5;

  logic          sync1;
  logic          int_sync;
  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          expired;

  // Treat zero as expired too, so a stray zero count can never stall a timed state.
  assign expired = (count <= CW'(1));

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (int_sync && bus.int_enable) begin
          state_next = P1;
          count_next = PULSE_LOAD;
        end
      end
      P1: begin
        if (expired) begin
          state_next = GAP;
          count_next = GAP_LOAD;
        end else begin
          count_next = count - CW'(1);
        end
      end
      GAP: begin
        if (expired) begin
          state_next = P2;
          count_next = PULSE_LOAD;
        end else begin
          count_next = count - CW'(1);
        end
      end
      P2: begin
        if (expired) begin
          state_next = HOLD;
        end else begin
          count_next = count - CW'(1);
        end
      end
      HOLD: begin
        if (bus.vec_ready) begin
          state_next = COOL;
          count_next = GAP_LOAD;
        end
      end
      COOL: begin
        if (expired) begin
          state_next = IDLE;
        end else begin
          count_next = count - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1         <= 1'b0;
      int_sync      <= 1'b0;
      state         <= IDLE;
      count         <= '0;
      bus.inta_n    <= 1'b1;
      bus.vector    <= 8'h00;
      bus.vec_valid <= 1'b0;
    end else begin
      sync1      <= bus.int_req;
      int_sync   <= sync1;
      state      <= state_next;
      count      <= count_next;
      // Registered from the next-state decode so the PIC sees a clean edge-aligned pulse.
      bus.inta_n <= !((state_next == P1) || (state_next == P2));
      if ((state == P2) && expired) begin
        bus.vector    <= bus.data_in;
        bus.vec_valid <= 1'b1;
      end else if ((state == HOLD) && bus.vec_ready) begin
        bus.vec_valid <= 1'b0;
      end
    end
  end

  assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_inta_sequencer.sv
// tb/tb_inta_sequencer.sv - self-checking bench for inta_sequencer
module tb_inta_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  inta_sequencer_if bus_a ();
  inta_sequencer_if bus_b ();

  inta_sequencer #(.PULSE_CYCLES(2), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.master)
  );
  inta_sequencer #(.PULSE_CYCLES(1), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.master)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_a.int_req = 0; bus_a.int_enable = 0; bus_a.data_in = 8'h00; bus_a.vec_ready = 0;
    bus_b.int_req = 0; bus_b.int_enable = 0; bus_b.data_in = 8'h00; bus_b.vec_ready = 0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (bus_a.inta_n !== 1'b1 || bus_a.vec_valid !== 1'b0 || bus_a.vector !== 8'h00 || bus_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_a got inta_n=%b vec_valid=%b vector=%h busy=%b want 1 0 00 0",
               bus_a.inta_n, bus_a.vec_valid, bus_a.vector, bus_a.busy);
    end
    checks++;
    if (bus_b.inta_n !== 1'b1 || bus_b.vec_valid !== 1'b0 || bus_b.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_b got inta_n=%b vec_valid=%b busy=%b want 1 0 0",
               bus_b.inta_n, bus_b.vec_valid, bus_b.busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Caller is just past an edge; the next edge is E1. Returns just past E9.
  task automatic run_ack_a(input logic [7:0] data, input bit drop);
    logic exp_n;
    bus_a.data_in = ~data;
    bus_a.int_enable = 1;
    bus_a.int_req = 1;
    exp_q.push_back(data);
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_n = !((k >= 3 && k < 5) || (k >= 7 && k < 9));
      checks++;
      if (bus_a.inta_n !== exp_n) begin
        errors++;
        $display("FAIL inta_n_a E%0d got %b want %b", k, bus_a.inta_n, exp_n);
      end
      if (drop && k == 5) begin
        bus_a.int_req = 0;
        bus_a.int_enable = 0;
      end
      if (k == 7) bus_a.data_in = data;
    end
    checks++;
    if (bus_a.vec_valid !== 1'b1 || bus_a.vector !== data) begin
      errors++;
      $display("FAIL capture_a got valid=%b vector=%h want 1 %h", bus_a.vec_valid, bus_a.vector, data);
    end
    bus_a.int_req = 0;
  endtask

  task automatic wait_valid_a();
    int n = 0;
    while (bus_a.vec_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus_a.vec_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid_a got vec_valid=%b want 1 within 50 cycles", bus_a.vec_valid);
    end
  endtask

  task automatic handshake_a(input int stall);
    logic [7:0] exp_v;
    exp_v = exp_q.pop_front();
    bus_a.vec_ready = 0;
    for (int i = 0; i < stall; i++) begin
      tick();
      checks++;
      if (bus_a.vec_valid !== 1'b1 || bus_a.vector !== exp_v || bus_a.inta_n !== 1'b1 || bus_a.busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_a cycle %0d got valid=%b vector=%h inta_n=%b busy=%b want 1 %h 1 1",
                 i, bus_a.vec_valid, bus_a.vector, bus_a.inta_n, bus_a.busy, exp_v);
      end
    end
    checks++;
    if (bus_a.vector !== exp_v) begin
      errors++;
      $display("FAIL scoreboard_a got vector=%h want %h", bus_a.vector, exp_v);
    end
    bus_a.vec_ready = 1;
    tick();
    bus_a.vec_ready = 0;
    checks++;
    if (bus_a.vec_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_a got vec_valid=%b want 0", bus_a.vec_valid);
    end
    tick();
    checks++;
    if (bus_a.busy !== 1'b1) begin
      errors++;
      $display("FAIL cool_a got busy=%b want 1", bus_a.busy);
    end
    tick();
    checks++;
    if (bus_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_a got busy=%b want 0", bus_a.busy);
    end
  endtask

  task automatic test_basic();
    run_ack_a(8'h4B, 1'b0);
    handshake_a(0);
    tick();
  endtask

  task automatic test_backpressure();
    run_ack_a(8'h4B, 1'b0);
    handshake_a(20);
    tick();
  endtask

  task automatic test_masked();
    bus_a.int_req = 1;
    bus_a.int_enable = 0;
    bus_a.vec_ready = 1;
    bus_a.data_in = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus_a.inta_n !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.vec_valid !== 1'b0) begin
        errors++;
        $display("FAIL masked_a cycle %0d got inta_n=%b busy=%b valid=%b want 1 0 0",
                 i, bus_a.inta_n, bus_a.busy, bus_a.vec_valid);
      end
    end
    bus_a.vec_ready = 0;
    bus_a.int_enable = 1;
    exp_q.push_back(8'h5A);
    tick();
    checks++;
    if (bus_a.inta_n !== 1'b0 || bus_a.busy !== 1'b1) begin
      errors++;
      $display("FAIL enable_a got inta_n=%b busy=%b want 0 1", bus_a.inta_n, bus_a.busy);
    end
    bus_a.int_req = 0;
    wait_valid_a();
    handshake_a(0);
    tick();
  endtask

  task automatic test_drop();
    run_ack_a(8'h47, 1'b1);
    handshake_a(0);
    tick();
  endtask

  task automatic test_reset_mid();
    bus_a.int_req = 1;
    bus_a.int_enable = 1;
    bus_a.data_in = 8'h99;
    for (int k = 1; k <= 7; k++) tick();
    checks++;
    if (bus_a.inta_n !== 1'b0) begin
      errors++;
      $display("FAIL p2_entry_a got inta_n=%b want 0", bus_a.inta_n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.inta_n !== 1'b1 || bus_a.vec_valid !== 1'b0 || bus_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_a got inta_n=%b valid=%b busy=%b want 1 0 0",
               bus_a.inta_n, bus_a.vec_valid, bus_a.busy);
    end
    tick();
    rst_n = 1'b1;
    run_ack_a(8'hC3, 1'b0);
    handshake_a(0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_n;
    int   k;
    bus_b.int_req = 1;
    bus_b.int_enable = 1;
    bus_b.data_in = 8'hE1;
    exp_q.push_back(8'hE1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_n = !(e == 3 || e == 7);
      checks++;
      if (bus_b.inta_n !== exp_n) begin
        errors++;
        $display("FAIL inta_n_b first E%0d got %b want %b", e, bus_b.inta_n, exp_n);
      end
    end
    checks++;
    if (bus_b.vec_valid !== 1'b1 || bus_b.vector !== exp_q[0]) begin
      errors++;
      $display("FAIL capture_b first got valid=%b vector=%h want 1 %h", bus_b.vec_valid, bus_b.vector, exp_q[0]);
    end
    void'(exp_q.pop_front());
    bus_b.data_in = 8'h2D;
    exp_q.push_back(8'h2D);
    bus_b.vec_ready = 1;
    tick();
    bus_b.vec_ready = 0;
    checks++;
    if (bus_b.vec_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_b got vec_valid=%b want 0", bus_b.vec_valid);
    end
    // Eh+4 plays the role of E3 for the second sequence.
    for (int j = 1; j <= 9; j++) begin
      tick();
      k = j - 1;
      exp_n = !(k == 3 || k == 7);
      checks++;
      if (bus_b.inta_n !== exp_n) begin
        errors++;
        $display("FAIL inta_n_b second Eh+%0d got %b want %b", j, bus_b.inta_n, exp_n);
      end
      if (j == 3) begin
        checks++;
        if (bus_b.busy !== 1'b0) begin
          errors++;
          $display("FAIL idle_b Eh+3 got busy=%b want 0", bus_b.busy);
        end
      end
    end
    bus_b.int_req = 0;
    checks++;
    if (bus_b.vec_valid !== 1'b1 || bus_b.vector !== exp_q[0]) begin
      errors++;
      $display("FAIL capture_b second got valid=%b vector=%h want 1 %h", bus_b.vec_valid, bus_b.vector, exp_q[0]);
    end
    void'(exp_q.pop_front());
    bus_b.vec_ready = 1;
    tick();
    bus_b.vec_ready = 0;
    for (int j = 0; j < 4; j++) tick();
    checks++;
    if (bus_b.busy !== 1'b0 || bus_b.vec_valid !== 1'b0 || bus_b.inta_n !== 1'b1) begin
      errors++;
      $display("FAIL final_b got busy=%b valid=%b inta_n=%b want 0 0 1", bus_b.busy, bus_b.vec_valid, bus_b.inta_n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_masked();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
